m_store_buffer: RTL
===================

# m_store_buffer

Store-side counterpart of the M-stage load data extender: encodes `sw`/`sh`/`sb` stores into word-aligned address, replicated write data and byte enables, and queues them in a small FIFO that drains to the data-memory port through a req/ack handshake. Sits in the M stage beside the load extender. Stalls the pipeline when full, and when a load hits a word with a pending store.

## Interface
- `DEPTH`, 4, number of buffered stores; power of two, ≥2.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `StoreEn` input 1: M-stage instruction is a store.
- `BEOp` input 2: store width; `BE_sw`=2'd0, `BE_sh`=2'd1, `BE_sb`=2'd2; 2'd3 is treated as no store.
- `Addr` input 32: byte address from ALU.
- `WD` input 32: store data (rt value, already forwarded).
- `LoadEn` input 1: M-stage instruction is a load, address on `Addr`.
- `Stall` output 1: hold M stage and upstream this cycle.
- `AdES` output 1: misaligned store exception; only present with `ALIGN_CHECK_EN`, otherwise tied 0.
- `Empty` output 1: no pending stores. Used to drain before eret/syscall.
- `m_data_req` output 1: head entry valid.
- `m_data_addr` output 32: head word address, `{addr[31:2],2'b00}`.
- `m_data_wdata` output 32: head write data.
- `m_data_byteen` output 4: head byte enables.
- `m_data_ack` input 1: memory accepts the head entry this cycle.

## Operation
- **Encode (combinational from `Addr`, `WD`, `BEOp`):**
  - sw: byteen 4'b1111, wdata = WD.
  - sh: byteen 4'b0011 << (2*Addr[1]), wdata = {WD[15:0], WD[15:0]}.
  - sb: byteen 4'b0001 << Addr[1:0], wdata = {4{WD[7:0]}}.
- **Entry:** {addr[31:2], wdata, byteen}. Storage is a circular FIFO with `rd_ptr`, `wr_ptr` (log2 DEPTH bits, wrapping) and `count` (0..DEPTH).
- **Push:** happens when `StoreEn && BEOp!=3 && !Stall && !AdES`.
- **Pop:** happens when `m_data_req && m_data_ack`.
- **Push and pop in the same cycle:** both happen and `count` is unchanged.
- **Full stall:** `Stall` is asserted when `StoreEn && count==DEPTH`. It is conservative: a same-cycle pop does not unblock the push.
- **Load hazard:** `Stall` is also asserted when `LoadEn && Addr[31:2]` equals the addr of any valid entry, including the head being acked this cycle. Loads to other words proceed without stalling.
- **Stall composition:** `Stall` = full stall OR load hazard. It is combinational from the inputs and the registered count/entries.
- **Outputs:** `m_data_*` are driven from the head entry registers. `m_data_req` = (count!=0). `Empty` = (count==0).
- **Unconnected handshake:** `m_data_ack` is ignored while `m_data_req`=0.

## Timing
- **Reset (asynchronous):** count=0, pointers=0, all entry registers 0. Outputs: `m_data_req`=0, `m_data_addr`=0, `m_data_wdata`=0, `m_data_byteen`=0, `Empty`=1, `Stall`=0 (unless inputs demand it), `AdES`=0.
- **Reset mid-drain:** every pending store is discarded and no further req is issued.
- **Push-to-request latency:** a store pushed at edge N appears on `m_data_req`/`m_data_*` after edge N, when the buffer was empty.
- **Throughput:** with `m_data_ack` held at 1, one entry drains per cycle.
- **Request hold:** the head stays stable while `m_data_req`=1 and `m_data_ack`=0.
- **Pointer wrap:** pointers wrap from DEPTH-1 to 0 with no bubble.

## Configuration
- `ALIGN_CHECK_EN` defined:
  - `AdES`=1 when `StoreEn` and either sw with Addr[1:0]!=0 or sh with Addr[0]!=0.
  - A faulting store is not enqueued and does not raise the full stall.
- `ALIGN_CHECK_EN` undefined:
  - `AdES`=0.
  - sw ignores Addr[1:0] and sh ignores Addr[0]; the store is enqueued with the encoding above.

## Test plan
- **Encode and drain:** after reset, sb Addr=0x1003, WD=0x000000AB, ack=1 → next cycle req=1, addr=0x1000, wdata=0xABABABAB, byteen=4'b1000; Empty=1 the cycle after.
- **Fill and full stall:** ack=0, 4 sw pushes, then a 5th sw → Stall=1 and count stays 4. Raise ack → one pop per cycle in FIFO order. The stalled store is accepted once count<4.
- **Wrap-around:** 6 stores interleaved with acks across pointer wrap; data order and byteen match, e.g. sh Addr=0x2002 WD=0x1234 → byteen 4'b1100, wdata 0x12341234.
- **Load hazard:** pending store to 0x3008, ack=0, LoadEn Addr=0x300A → Stall=1. LoadEn Addr=0x300C → Stall=0.
- **Misalignment (ALIGN_CHECK_EN):** sw Addr=0x4001 → AdES=1, no enqueue, Empty stays 1. Without the macro: req with addr=0x4000, byteen=4'b1111.
- **Reset mid-operation:** 3 entries pending, ack=0, reset pulsed low → req=0 and Empty=1 immediately (asynchronous), and stay so after release.

Source files
------------

// File: rtl/m_store_buffer.sv
// M-stage store buffer: encodes sw/sh/sb into word address, lane-replicated data and byte
// enables, queues them in a DEPTH-entry FIFO drained over req/ack. Option: ALIGN_CHECK_EN.
module m_store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StoreEn,
    input  logic [1:0]  BEOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic        LoadEn,
    output logic        Stall,
    output logic        AdES,
    output logic        Empty,
    output logic        m_data_req,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic        m_data_ack
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] BE_SW = 2'd0;
    localparam logic [1:0] BE_SH = 2'd1;
    localparam logic [1:0] BE_SB = 2'd2;
    localparam logic [1:0] BE_NONE = 2'd3;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } sb_entry_t;

    sb_entry_t              entry_q [DEPTH];
    sb_entry_t              entry_d [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    sb_entry_t              new_entry;
    logic [DEPTH-1:0]       valid;
    logic                   misaligned;
    logic                   full_stall;
    logic                   load_hit;
    logic                   push;
    logic                   pop;
    sb_entry_t              head;

    // Store encoding: replicate data across lanes, select lanes by address.
    always_comb begin
        new_entry.waddr  = Addr[31:2];
        new_entry.wdata  = WD;
        new_entry.byteen = 4'b0000;
        case (BEOp)
            BE_SW: begin
                new_entry.wdata  = WD;
                new_entry.byteen = 4'b1111;
            end
            BE_SH: begin
                new_entry.wdata  = {WD[15:0], WD[15:0]};
                new_entry.byteen = Addr[1] ? 4'b1100 : 4'b0011;
            end
            BE_SB: begin
                new_entry.wdata  = {4{WD[7:0]}};
                new_entry.byteen = 4'b0001 << Addr[1:0];
            end
            default: begin
                new_entry.wdata  = WD;
                new_entry.byteen = 4'b0000;
            end
        endcase
    end

`ifdef ALIGN_CHECK_EN
    assign misaligned = StoreEn && (((BEOp == BE_SW) && (Addr[1:0] != 2'b00)) ||
                                    ((BEOp == BE_SH) && Addr[0]));
`else
    assign misaligned = 1'b0;
`endif

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q);
        end
    end

    always_comb begin
        load_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entry_q[i].waddr == Addr[31:2])) begin
                load_hit = 1'b1;
            end
        end
        load_hit = load_hit && LoadEn;
    end

    // Full stall ignores a same-cycle pop to keep the path short.
    assign full_stall = StoreEn && !misaligned && (count_q == CNT_W'(DEPTH));
    assign Stall      = full_stall || load_hit;
    assign AdES       = misaligned;
    assign push       = StoreEn && (BEOp != BE_NONE) && !Stall && !misaligned;
    assign pop        = (count_q != '0) && m_data_ack;

    always_comb begin
        entry_d  = entry_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            entry_d[wr_ptr_q] = new_entry;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign head          = entry_q[rd_ptr_q];
    assign m_data_req    = (count_q != '0);
    assign Empty         = (count_q == '0);
    assign m_data_addr   = {head.waddr, 2'b00};
    assign m_data_wdata  = head.wdata;
    assign m_data_byteen = head.byteen;

endmodule
